// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multi-cycle control FSM for the mips_core datapath. Decodes
//               opcode/funct, sequences FETCH..WRITEBACK, drives every
//               datapath strobe and stalls on the memory ready handshake.
//               Traps on illegal opcodes and on memory timeouts.
//               Optional macro MIPS_CTRL_PERF_EN adds instr_count and
//               cycle_count performance counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_j     = 6'h02;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  localparam logic [3:0] c_alu_add = 4'd0;
  localparam logic [3:0] c_alu_sub = 4'd1;
  localparam logic [3:0] c_alu_and = 4'd2;
  localparam logic [3:0] c_alu_or  = 4'd3;
  localparam logic [3:0] c_alu_slt = 4'd4;

  // Last count value before a still-waiting memory state gives up
  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_illegal;
  logic       r_mem_err;
  logic       w_mem_wait;
  logic       w_timeout;
  logic       w_rtype_ok;
  logic [3:0] w_funct_op;

  // R-type funct decode: legality and ALU operation
  always_comb begin
    w_rtype_ok = 1'b1;
    w_funct_op = c_alu_add;
    case (funct)
      c_fn_add: w_funct_op = c_alu_add;
      c_fn_sub: w_funct_op = c_alu_sub;
      c_fn_and: w_funct_op = c_alu_and;
      c_fn_or:  w_funct_op = c_alu_or;
      c_fn_slt: w_funct_op = c_alu_slt;
      default:  w_rtype_ok = 1'b0;
    endcase
  end

  // Memory-wait states and the timeout condition (ready on the last cycle wins)
  always_comb begin
    w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    w_timeout  = w_mem_wait && !mem_ready && (r_wait_cnt == c_wait_last);
  end

  // Next-state logic and datapath strobes decoded from the current state
  always_comb begin
    w_next     = r_state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = c_alu_add;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_op_rtype: w_next = w_rtype_ok ? S_EXEC_R : S_TRAP;
          c_op_addi:  w_next = S_EXEC_I;
          c_op_lw:    w_next = S_MEM_ADDR;
          c_op_sw:    w_next = S_MEM_ADDR;
          c_op_beq:   w_next = S_BRANCH;
          c_op_j:     w_next = S_JUMP;
          default:    w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = w_funct_op;
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_op_sw) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready)      w_next = S_WB_MEM;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = run ? S_FETCH : S_IDLE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == c_op_rtype);
        instr_done = 1'b1;
        w_next     = run ? S_FETCH : S_IDLE;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        w_next     = run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = c_alu_sub;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        w_next     = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        w_next     = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register, memory wait counter and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_illegal  <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mem_wait && (w_next == r_state)) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                                   r_wait_cnt <= 8'd0;
      if ((r_state == S_DECODE) && (w_next == S_TRAP)) r_illegal <= 1'b1;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

  assign state      = r_state;
  assign illegal_op = r_illegal;
  assign mem_err    = r_mem_err;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_cycle_count;

  // Retired-instruction and busy-cycle counters, wrapping at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr_count <= 32'd0;
      r_cycle_count <= 32'd0;
    end else begin
      if (instr_done) r_instr_count <= r_instr_count + 32'd1;
      if ((r_state != S_IDLE) && (r_state != S_TRAP)) r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
  assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Self-checking bench for mips_multicycle_ctrl. Each instruction
//               is expanded into its list of phases, memory phases are
//               stretched by random stalls, and every cycle's outputs are
//               compared against the phase's expected strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam int c_timeout = 4;

  logic        clock = 1'b0;
  logic        reset, run, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_op, state;
  logic        instr_done, illegal_op, mem_err;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] instr_count, cycle_count;
`endif

  mips_multicycle_ctrl #(.MEM_TIMEOUT(c_timeout)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_err(mem_err)
`ifdef MIPS_CTRL_PERF_EN
    , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic       rd, wr, irw, pcw, rw, rdst, m2r, sa;
    logic [1:0] sb;
    logic [3:0] op;
    logic [1:0] ps;
    logic       done, ill, merr;
  } sig_t;

  int         errors = 0;
  int         checks = 0;
  logic       m_ill, m_merr, m_idle;
  logic [5:0] cur_op, cur_fn;

  function automatic logic [3:0] funct_op(logic [5:0] fn);
    case (fn)
      6'h22:   return 4'd1;
      6'h24:   return 4'd2;
      6'h25:   return 4'd3;
      6'h2A:   return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // Expected strobes for a phase, from the control table
  function automatic sig_t expect_sig(int s, logic rdy, logic z);
    sig_t e;
    e      = '0;
    e.st   = 4'(s);
    e.ill  = m_ill;
    e.merr = m_merr;
    case (s)
      1:       begin e.rd = 1'b1; e.sb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      2:       e.sb = 2'b11;
      3:       begin e.sa = 1'b1; e.op = funct_op(cur_fn); end
      4, 5:    begin e.sa = 1'b1; e.sb = 2'b10; end
      6:       e.rd = 1'b1;
      7:       begin e.wr = 1'b1; e.done = rdy; end
      8:       begin e.rw = 1'b1; e.rdst = (cur_op == 6'h00); e.done = 1'b1; end
      9:       begin e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1; end
      10:      begin e.sa = 1'b1; e.op = 4'd1; e.ps = 2'b01; e.pcw = z; e.done = 1'b1; end
      11:      begin e.ps = 2'b10; e.pcw = 1'b1; e.done = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(string tag, sig_t exp);
    sig_t obs;
    obs = {state, mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, mem_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (state %0d vs %0d)", tag, obs, exp, obs.st, exp.st);
    end
  endtask

  // One clock cycle in phase s: drive inputs on negedge, compare, advance to posedge
  task automatic cyc(string tag, int s, logic rdy, logic rn, logic z);
    @(negedge clock);
    mem_ready = rdy;
    run       = rn;
    zero      = z;
    if (s <= 1) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end else begin
      opcode = cur_op;
      funct  = cur_fn;
    end
    #1;
    check(tag, expect_sig(s, rdy, z));
    @(posedge clock);
  endtask

  task automatic do_reset(int n);
    @(negedge clock);
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    repeat (n) @(posedge clock);
    @(negedge clock);
    m_ill  = 1'b0;
    m_merr = 1'b0;
    #1;
    check("reset", expect_sig(0, 1'b1, 1'b1));
    reset = 1'b0;
    run   = 1'b0;
    @(posedge clock);
    m_idle = 1'b1;
  endtask

  // Execute one legal instruction; stall<0 picks a random non-trapping stall per memory phase
  task automatic run_instr(string tag, logic [5:0] op, logic [5:0] fn, logic z, int stall, logic last_run);
    int   q[$];
    int   s, n;
    logic fin, rn;
    cur_op = op;
    cur_fn = fn;
    if (m_idle) q.push_back(0);
    q.push_back(1);
    q.push_back(2);
    case (op)
      6'h00:   begin q.push_back(3); q.push_back(8); end
      6'h08:   begin q.push_back(4); q.push_back(8); end
      6'h23:   begin q.push_back(5); q.push_back(6); q.push_back(9); end
      6'h2B:   begin q.push_back(5); q.push_back(7); end
      6'h04:   q.push_back(10);
      default: q.push_back(11);
    endcase
    foreach (q[i]) begin
      s   = q[i];
      fin = (i == q.size() - 1);
      if (s == 0) rn = 1'b1;
      else if (fin) rn = last_run;
      else rn = 1'($urandom);
      if (s == 1 || s == 6 || s == 7) begin
        n = (stall < 0) ? int'($urandom_range(0, c_timeout - 1)) : stall;
        repeat (n) cyc(tag, s, 1'b0, 1'($urandom), 1'($urandom));
        cyc(tag, s, 1'b1, rn, 1'($urandom));
      end else begin
        cyc(tag, s, 1'($urandom), rn, (s == 10) ? z : 1'($urandom));
      end
    end
    m_idle = !last_run;
  endtask

  task automatic run_illegal(string tag, logic [5:0] op, logic [5:0] fn, int trap_cycles);
    cur_op = op;
    cur_fn = fn;
    if (m_idle) cyc(tag, 0, 1'b1, 1'b1, 1'b0);
    cyc(tag, 1, 1'b1, 1'b1, 1'b0);
    cyc(tag, 2, 1'($urandom), 1'($urandom), 1'($urandom));
    m_ill = 1'b1;
    repeat (trap_cycles) cyc(tag, 12, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic run_fetch_timeout();
    cur_op = 6'h08;
    cur_fn = 6'h00;
    if (m_idle) cyc("to_idle", 0, 1'b1, 1'b1, 1'b0);
    repeat (c_timeout) cyc("to_fetch", 1, 1'b0, 1'($urandom), 1'($urandom));
    m_merr = 1'b1;
    repeat (5) cyc("to_trap", 12, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  logic [5:0] ops[6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
  logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    opcode = 6'h00; funct = 6'h00;
    m_ill = 1'b0; m_merr = 1'b0; m_idle = 1'b1;
    cur_op = 6'h00; cur_fn = 6'h00;

    do_reset(3);
    run_instr("add",     6'h00, 6'h20, 1'b0, 0, 1'b1);
    run_instr("lw_stall", 6'h23, 6'h00, 1'b0, 3, 1'b1);
    run_instr("beq_z1",  6'h04, 6'h00, 1'b1, 0, 1'b1);
    run_instr("beq_z0",  6'h04, 6'h00, 1'b0, 0, 1'b1);
    run_instr("sub",     6'h00, 6'h22, 1'b0, 0, 1'b1);
    run_instr("and",     6'h00, 6'h24, 1'b0, 0, 1'b1);
    run_instr("or",      6'h00, 6'h25, 1'b0, 0, 1'b1);
    run_instr("slt",     6'h00, 6'h2A, 1'b0, 0, 1'b1);
    run_instr("addi",    6'h08, 6'h11, 1'b0, 0, 1'b1);
    run_instr("sw",      6'h2B, 6'h00, 1'b0, 1, 1'b1);
    run_instr("j",       6'h02, 6'h00, 1'b0, 0, 1'b0);
    run_instr("from_idle", 6'h00, 6'h25, 1'b0, 0, 1'b1);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ops[$urandom_range(0, 5)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr("random", op, fn, 1'($urandom), -1, 1'($urandom));
    end

    run_illegal("illegal_3f", 6'h3F, 6'h00, 20);
    do_reset(2);
    run_illegal("illegal_funct", 6'h00, 6'h21, 3);
    do_reset(1);
    run_fetch_timeout();
    do_reset(1);
    run_instr("ready_last", 6'h00, 6'h20, 1'b0, c_timeout - 1, 1'b1);
    run_instr("rd_last",    6'h23, 6'h00, 1'b0, c_timeout - 1, 1'b0);

    // Reset during MEM_WR with ready and run high: reset must win
    cur_op = 6'h2B;
    cur_fn = 6'h00;
    cyc("rst_wr", 0, 1'b1, 1'b1, 1'b0);
    cyc("rst_wr", 1, 1'b1, 1'b1, 1'b0);
    cyc("rst_wr", 2, 1'b1, 1'b1, 1'b0);
    cyc("rst_wr", 5, 1'b1, 1'b1, 1'b0);
    cyc("rst_wr", 7, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; run = 1'b1;
    @(posedge clock);
    #1;
    check("rst_in_memwr", expect_sig(0, 1'b1, 1'b0));
    @(negedge clock);
    reset = 1'b0;
    run   = 1'b0;
    @(posedge clock);
    m_idle = 1'b1;

`ifdef MIPS_CTRL_PERF_EN
    do_reset(1);
    checks++;
    assert (instr_count === 32'd0 && cycle_count === 32'd0) else begin
      errors++;
      $error("FAIL perf_reset: observed=%0d/%0d expected=0/0", instr_count, cycle_count);
    end
    for (int k = 0; k < 10; k++) run_instr("perf_addi", 6'h08, 6'h00, 1'b0, 0, (k < 9));
    #1;
    checks++;
    assert (instr_count === 32'd10 && cycle_count === 32'd40) else begin
      errors++;
      $error("FAIL perf_count: observed=%0d/%0d expected=10/40", instr_count, cycle_count);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
